cv32e40p_sleep_ctrl: RTL
========================

Name: cv32e40p_sleep_ctrl

Overview:
- SoC-side counterpart of the core's sleep/clock-gate logic; it sits outside the core.
- Boots the core with a fetch-enable pulse and watches core_sleep. Once sleep is confirmed it removes the core clock via core_clock_en_o.
- Holds interrupts and debug requests away from the core while its clock is off. Wakes the core on a masked interrupt or a debug request.
- Keeps a saturating sleep-cycle statistics counter.

Parameters:
- BOOT_DELAY, 4: cycles after reset before fetch_enable_o pulses (0 allowed).
- SLEEP_FILTER, 2: consecutive core_sleep_i=1 cycles needed before the clock is gated (>=1).
- WAKE_DELAY, 3: cycles the clock runs before irq/debug are released to the core (>=1).
- CNT_W, 32: width of the sleep-cycle counter.

Ports:
- clk_i  in  1  free-running clock.
- rst_i  in  1  reset, synchronous, active-high.
- boot_en_i  in  1  allows leaving BOOT.
- fetch_enable_o  out  1  one-cycle pulse to the core fetch enable.
- core_sleep_i  in  1  core sleep indication.
- core_clock_en_o  out  1  enable for the SoC clock gate feeding the core.
- irq_src_i  in  32  interrupt sources.
- irq_mask_i  in  32  wake-capable interrupt mask.
- irq_o  out  32  interrupts forwarded to the core.
- debug_req_src_i  in  1  debug request source.
- debug_req_o  out  1  debug request forwarded to the core.
- sleeping_o  out  1  high while state is SLEEP.
- sleep_cycles_o  out  CNT_W  count of cycles spent in SLEEP.
- sleep_cycles_clr_i  in  1  clears sleep_cycles_o.
- protocol_err_o  out  1  sticky flag for a protocol violation.

Behaviour:
- States: BOOT, RUN, SLEEP_PEND, SLEEP, WAKE. Reset state is BOOT.
- Reset values: core_clock_en_o=1, fetch_enable_o=0, irq_o=0, debug_req_o=0, sleeping_o=0, sleep_cycles_o=0, protocol_err_o=0; all counters 0.
- A reset in any state, including SLEEP or WAKE, returns to BOOT next cycle with these values; the core clock is re-enabled immediately.
- Definition: wake = |(irq_src_i & irq_mask_i) | debug_req_src_i.
- core_clock_en_o = (state != SLEEP).
- Forwarding, combinational with zero latency:
  - irq_o = irq_src_i and debug_req_o = debug_req_src_i when state is RUN or SLEEP_PEND.
  - Both are 0 otherwise, so nothing reaches the core in BOOT, SLEEP or WAKE.
- BOOT:
  - The counter increments only while boot_en_i=1.
  - When the count equals BOOT_DELAY with boot_en_i=1: fetch_enable_o=1 for exactly that cycle, then go to RUN.
  - With BOOT_DELAY=0 the pulse occurs in the first cycle with boot_en_i=1.
  - fetch_enable_o never pulses again until the next reset.
- RUN: if core_sleep_i=1 and wake=0, go to SLEEP_PEND with the filter counter set to 1.
- SLEEP_PEND:
  - If core_sleep_i=0 or wake=1, go to RUN and clear the filter counter. Wake has priority over gating.
  - Otherwise, if the filter counter equals SLEEP_FILTER, go to SLEEP; else increment the counter.
  - With SLEEP_FILTER=1, SLEEP is entered on the cycle after SLEEP_PEND is entered.
- SLEEP:
  - Clock gated; sleeping_o=1.
  - sleep_cycles_o increments each cycle and saturates at all-ones.
  - If wake=1, go to WAKE with the wake counter at 0. Sources are level-sensitive and not latched.
- WAKE:
  - The clock runs while irq/debug are still masked. The wake counter increments.
  - When the count equals WAKE_DELAY-1, go to RUN; forwarding starts in the first RUN cycle.
  - WAKE therefore lasts exactly WAKE_DELAY cycles.
  - If the wake source disappears during WAKE, still go to RUN; the core sees nothing and re-requests sleep.
- sleep_cycles_clr_i: zeroes the counter next cycle. A clear has priority over an increment in the same cycle.
- protocol_err_o is set and stays set until reset when either:
  - core_sleep_i=0 while in SLEEP; or
  - core_sleep_i=1 while in BOOT.
  - The state machine is not affected.

Test Plan:
- Boot: BOOT_DELAY=4, boot_en_i=1 from reset release -> fetch_enable_o high only in cycle 4 (cycles counted from 0), state RUN from cycle 5, core_clock_en_o=1 throughout. Holding boot_en_i=0 -> no pulse.
- Sleep entry: SLEEP_FILTER=2, core_sleep_i rises at cycle t and stays high -> core_clock_en_o=0 and sleeping_o=1 from t+3. sleep_cycles_o reads 10 after 10 SLEEP cycles.
- Glitch and wake race:
  - core_sleep_i high for 1 cycle only -> never reaches SLEEP.
  - irq_src_i=0x4 with irq_mask_i=0x4 during SLEEP_PEND -> irq_o=0x4 same cycle, returns to RUN, clock never gated.
- Wake:
  - In SLEEP, irq_src_i=0x10 with mask 0x10 -> core_clock_en_o=1 next cycle; irq_o stays 0 for 3 WAKE cycles, then irq_o=0x10.
  - Unmasked irq_src_i=0x1 in SLEEP -> stays asleep.
  - debug_req_src_i alone also wakes.
- Counter: force sleep_cycles_o to all-ones -> holds. Asserting sleep_cycles_clr_i during SLEEP -> reads 0 next cycle.
- Reset and errors:
  - rst_i asserted in SLEEP -> next cycle BOOT, core_clock_en_o=1, sleep_cycles_o=0.
  - core_sleep_i dropping in SLEEP -> protocol_err_o=1 and sticky.

Source files
------------

// File: rtl/cv32e40p_sleep_ctrl.sv
// SoC-side sleep controller for a CV32E40P core.
// Boots the core with a single fetch-enable pulse, filters the core's sleep
// indication before gating its clock, and holds interrupts and debug requests
// away from the core until its clock has been running for a few cycles again.
// Also keeps a saturating count of cycles spent asleep and a sticky flag for
// sleep-protocol violations.
module cv32e40p_sleep_ctrl #(
  parameter int BOOT_DELAY   = 4,
  parameter int SLEEP_FILTER = 2,
  parameter int WAKE_DELAY   = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             boot_en_i,
  output logic             fetch_enable_o,
  input  logic             core_sleep_i,
  output logic             core_clock_en_o,
  input  logic [31:0]      irq_src_i,
  input  logic [31:0]      irq_mask_i,
  output logic [31:0]      irq_o,
  input  logic             debug_req_src_i,
  output logic             debug_req_o,
  output logic             sleeping_o,
  output logic [CNT_W-1:0] sleep_cycles_o,
  input  logic             sleep_cycles_clr_i,
  output logic             protocol_err_o
);

  localparam logic [2:0] S_BOOT       = 3'd0;
  localparam logic [2:0] S_RUN        = 3'd1;
  localparam logic [2:0] S_SLEEP_PEND = 3'd2;
  localparam logic [2:0] S_SLEEP      = 3'd3;
  localparam logic [2:0] S_WAKE       = 3'd4;

  // Counter widths sized to hold their terminal values; never narrower than 1.
  localparam int BOOT_W = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam int FILT_W = $clog2(SLEEP_FILTER + 1);
  localparam int WAKE_W = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;

  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_DELAY);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(SLEEP_FILTER);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_DELAY - 1);

  logic [2:0]        state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0]  sleep_cnt_q, sleep_cnt_d;
  logic              err_q, err_d;

  logic wake;
  logic fwd;

  // A wake event is any enabled interrupt or a debug request; both are levels.
  assign wake = (|(irq_src_i & irq_mask_i)) | debug_req_src_i;

  // Only a core whose clock has settled may see interrupts or debug requests.
  assign fwd = (state_q == S_RUN) || (state_q == S_SLEEP_PEND);

  assign irq_o           = fwd ? irq_src_i : '0;
  assign debug_req_o     = fwd & debug_req_src_i;
  assign core_clock_en_o = (state_q != S_SLEEP);
  assign sleeping_o      = (state_q == S_SLEEP);
  assign sleep_cycles_o  = sleep_cnt_q;
  assign protocol_err_o  = err_q;

  // The pulse happens only on the BOOT exit cycle, so it cannot recur until reset.
  assign fetch_enable_o = !rst_i && (state_q == S_BOOT) && boot_en_i &&
                          (boot_cnt_q == BOOT_LAST);

  // Next-state and counter updates for the boot/sleep/wake sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    filt_cnt_d = filt_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      S_BOOT: begin
        if (boot_en_i) begin
          if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
          else                         boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (core_sleep_i && !wake) begin
          state_d    = S_SLEEP_PEND;
          filt_cnt_d = FILT_W'(1);
        end
      end
      S_SLEEP_PEND: begin
        // A pending wake always beats clock gating.
        if (!core_sleep_i || wake) begin
          state_d    = S_RUN;
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_LAST) begin
          state_d = S_SLEEP;
        end else begin
          filt_cnt_d = filt_cnt_q + 1'b1;
        end
      end
      S_SLEEP: begin
        if (wake) begin
          state_d    = S_WAKE;
          wake_cnt_d = '0;
        end
      end
      S_WAKE: begin
        // Return to RUN even if the source vanished; the core simply sleeps again.
        if (wake_cnt_q == WAKE_LAST) state_d = S_RUN;
        else                         wake_cnt_d = wake_cnt_q + 1'b1;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Saturating sleep-cycle statistics; a clear wins over an increment.
  always_comb begin
    sleep_cnt_d = sleep_cnt_q;
    if (sleep_cycles_clr_i)                            sleep_cnt_d = '0;
    else if (state_q == S_SLEEP && sleep_cnt_q != '1)  sleep_cnt_d = sleep_cnt_q + 1'b1;
  end

  // Sticky violation flag: core awake while gated, or asleep before it was booted.
  assign err_d = err_q |
                 ((state_q == S_SLEEP) && !core_sleep_i) |
                 ((state_q == S_BOOT)  &&  core_sleep_i);

  // State registers with synchronous reset back to BOOT.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      filt_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      sleep_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      filt_cnt_q  <= filt_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      sleep_cnt_q <= sleep_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule
